l1_icache: RTL and testbench

L1_ICACHE -- requirements
Module: l1_icache

---
 rtl/l1_icache.sv | 175 +++++++++++++++++
 tb/tb_l1_icache.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_icache.sv
// l1_icache -- direct-mapped, read-only L1 instruction cache.
//
// Purpose:
//   Each set holds one 64-byte (512-bit) line, with a valid bit and a tag.
//   A hit returns the whole line one cycle after the request and can run every
//   cycle. A miss sends a line-aligned refill request to L2 and holds it until
//   L2 returns the line. The line is installed, and the response comes out in
//   the following cycle (RESP). Requests that arrive while a refill is in
//   flight, or during RESP, are ignored.
//
// Optional feature (macro L1I_SNOOP_INV_EN):
//   When the macro is defined, every cycle with m_axi_acsnoop == 4'hD
//   invalidates the matching line (same index and tag). When it is undefined,
//   the snoop ports are ignored and lines are cleared only by reset.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   S_R_ADDR/_VALID       fetch byte address and request valid
//   S_R_DATA/_VALID       full line containing the fetch address; one-cycle strobe
//   L2_S_R_ADDR/_VALID    line-aligned refill request, held until the refill is done
//   L2_S_R_DATA/_VALID    refill line and refill-complete strobe
//   m_axi_acsnoop/acaddr  snoop type and snoop address
module l1_icache #(
  parameter int NUM_SETS = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [63:0]  S_R_ADDR,
  input  logic         S_R_ADDR_VALID,
  output logic [511:0] S_R_DATA,
  output logic         S_R_DATA_VALID,
  output logic [63:0]  L2_S_R_ADDR,
  output logic         L2_S_R_ADDR_VALID,
  input  logic [511:0] L2_S_R_DATA,
  input  logic         L2_S_R_DATA_VALID,
  input  logic [3:0]   m_axi_acsnoop,
  input  logic [63:0]  m_axi_acaddr
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 64 - 6 - IDX_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MISS = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]          state_reg;
  logic [NUM_SETS-1:0] valid_reg;
  logic [NUM_SETS-1:0] valid_next;
  logic [TAG_W-1:0]    tag_mem [NUM_SETS];
  logic [511:0]        data_mem [NUM_SETS];

  logic [63:0]         l2_addr_reg;
  logic                l2_valid_reg;
  logic [511:0]        resp_data_reg;
  logic                resp_valid_reg;
  // Set once the requester lets go of S_R_ADDR_VALID during a refill. The
  // refill still installs, but no response strobe is sent.
  logic                drop_reg;

  logic [IDX_W-1:0]    req_idx, fill_idx, snp_idx;
  logic [TAG_W-1:0]    req_tag, fill_tag, snp_tag;
  logic                snp_req;
  logic                fill_we;
  logic                lookup_kill;
  logic                req_hit;

  assign req_idx  = S_R_ADDR[6 +: IDX_W];
  assign req_tag  = S_R_ADDR[63 -: TAG_W];
  assign fill_idx = l2_addr_reg[6 +: IDX_W];
  assign fill_tag = l2_addr_reg[63 -: TAG_W];

  logic unused_bits;
`ifdef L1I_SNOOP_INV_EN
  assign snp_req     = (m_axi_acsnoop == 4'hD);
  assign snp_idx     = m_axi_acaddr[6 +: IDX_W];
  assign snp_tag     = m_axi_acaddr[63 -: TAG_W];
  assign unused_bits = ^{S_R_ADDR[5:0], m_axi_acaddr[5:0]};
`else
  assign snp_req     = 1'b0;
  assign snp_idx     = '0;
  assign snp_tag     = '0;
  assign unused_bits = ^{S_R_ADDR[5:0], m_axi_acsnoop, m_axi_acaddr};
`endif

  assign fill_we = (state_reg == MISS) && L2_S_R_DATA_VALID;

  // A snoop that hits the line being looked up in the same cycle wins. The
  // lookup is then treated as a miss, so stale data is never returned.
  assign lookup_kill = snp_req && (snp_idx == req_idx) && (snp_tag == req_tag);
  assign req_hit     = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag) && !lookup_kill;

  // Per-set valid update. In a refill cycle, the snoop is compared against the
  // incoming tag rather than the outgoing one. This way a snoop of the line
  // being refilled leaves that line invalid.
  for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_valid
    logic fill_here;
    logic snoop_here;
    assign fill_here  = fill_we && (fill_idx == IDX_W'(gi));
    assign snoop_here = snp_req && (snp_idx == IDX_W'(gi)) &&
                        (fill_here ? (snp_tag == fill_tag)
                                   : (valid_reg[gi] && (tag_mem[gi] == snp_tag)));
    assign valid_next[gi] = snoop_here ? 1'b0 :
                            fill_here  ? 1'b1 : valid_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_next;
    end
  end

  // Tag and data arrays have no reset; the valid bits decide whether an entry counts.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[fill_idx] <= L2_S_R_DATA;
      tag_mem[fill_idx]  <= fill_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      l2_addr_reg    <= '0;
      l2_valid_reg   <= 1'b0;
      resp_data_reg  <= '0;
      resp_valid_reg <= 1'b0;
      drop_reg       <= 1'b0;
    end else begin
      resp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (S_R_ADDR_VALID) begin
            if (req_hit) begin
              resp_data_reg  <= data_mem[req_idx];
              resp_valid_reg <= 1'b1;
            end else begin
              l2_addr_reg  <= {S_R_ADDR[63:6], 6'b0};
              l2_valid_reg <= 1'b1;
              drop_reg     <= 1'b0;
              state_reg    <= MISS;
            end
          end
        end
        MISS: begin
          if (!S_R_ADDR_VALID) begin
            drop_reg <= 1'b1;
          end
          if (L2_S_R_DATA_VALID) begin
            l2_valid_reg <= 1'b0;
            state_reg    <= RESP;
            if (S_R_ADDR_VALID && !drop_reg) begin
              resp_data_reg  <= L2_S_R_DATA;
              resp_valid_reg <= 1'b1;
            end
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign S_R_DATA          = resp_data_reg;
  assign S_R_DATA_VALID    = resp_valid_reg;
  assign L2_S_R_ADDR       = l2_addr_reg;
  assign L2_S_R_ADDR_VALID = l2_valid_reg;

endmodule

// File: tb/tb_l1_icache.sv
// tb_l1_icache -- self-checking bench for l1_icache.
// The bench first runs a directed sequence with hand-computed expectations,
// then runs randomized traffic against a line-level cache model.
module tb_l1_icache;

  localparam int NS = 64;

  logic         clk;
  logic         reset;
  logic [63:0]  S_R_ADDR;
  logic         S_R_ADDR_VALID;
  logic [511:0] S_R_DATA;
  logic         S_R_DATA_VALID;
  logic [63:0]  L2_S_R_ADDR;
  logic         L2_S_R_ADDR_VALID;
  logic [511:0] L2_S_R_DATA;
  logic         L2_S_R_DATA_VALID;
  logic [3:0]   m_axi_acsnoop;
  logic [63:0]  m_axi_acaddr;

  l1_icache #(.NUM_SETS(NS)) dut (
    .clk               (clk),
    .reset             (reset),
    .S_R_ADDR          (S_R_ADDR),
    .S_R_ADDR_VALID    (S_R_ADDR_VALID),
    .S_R_DATA          (S_R_DATA),
    .S_R_DATA_VALID    (S_R_DATA_VALID),
    .L2_S_R_ADDR       (L2_S_R_ADDR),
    .L2_S_R_ADDR_VALID (L2_S_R_ADDR_VALID),
    .L2_S_R_DATA       (L2_S_R_DATA),
    .L2_S_R_DATA_VALID (L2_S_R_DATA_VALID),
    .m_axi_acsnoop     (m_axi_acsnoop),
    .m_axi_acaddr      (m_axi_acaddr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk512(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // ---------------- behavioural model: what each set holds, by line address ----
  bit              m_valid [NS];
  longint unsigned m_line  [NS];
  logic [511:0]    m_data  [NS];
  bit              model_ok = 1'b0;
  bit              busy = 1'b0;       // refill outstanding
  bit              replying = 1'b0;   // cycle right after a refill lands
  bit              abandoned = 1'b0;
  longint unsigned pending = 0;
  logic [511:0]    exp_data = '0;
  logic            exp_dvalid = 1'b0;
  logic [63:0]     exp_l2addr = '0;
  logic            exp_l2valid = 1'b0;

  task automatic model_step();
    bit              snp;
    longint unsigned sline, line;
    int              s;
    if (reset) begin
      model_ok = 1'b1;
      for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
      busy = 1'b0; replying = 1'b0; abandoned = 1'b0;
      exp_data = '0; exp_dvalid = 1'b0; exp_l2addr = '0; exp_l2valid = 1'b0;
    end else if (model_ok) begin
      snp = 1'b0;
`ifdef L1I_SNOOP_INV_EN
      snp = (m_axi_acsnoop == 4'hD);
`endif
      sline = m_axi_acaddr >> 6;
      s = int'(sline % NS);
      if (snp && m_valid[s] && m_line[s] == sline) m_valid[s] = 1'b0;
      exp_dvalid = 1'b0;
      if (replying) begin
        replying = 1'b0;
      end else if (busy) begin
        if (!S_R_ADDR_VALID) abandoned = 1'b1;
        if (L2_S_R_DATA_VALID) begin
          s = int'(pending % NS);
          m_line[s]  = pending;
          m_data[s]  = L2_S_R_DATA;
          m_valid[s] = !(snp && sline == pending);
          busy = 1'b0;
          replying = 1'b1;
          exp_l2valid = 1'b0;
          if (!abandoned) begin
            exp_data = L2_S_R_DATA;
            exp_dvalid = 1'b1;
          end
        end
      end else if (S_R_ADDR_VALID) begin
        line = S_R_ADDR >> 6;
        s = int'(line % NS);
        if (m_valid[s] && m_line[s] == line) begin
          exp_data = m_data[s];
          exp_dvalid = 1'b1;
        end else begin
          busy = 1'b1;
          abandoned = 1'b0;
          pending = line;
          exp_l2addr = 64'(line << 6);
          exp_l2valid = 1'b1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: outputs are checked half a cycle after each active edge.
  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      chk1("m_dvalid", S_R_DATA_VALID, exp_dvalid);
      chk512("m_data", S_R_DATA, exp_data);
      chk1("m_l2valid", L2_S_R_ADDR_VALID, exp_l2valid);
      if (exp_l2valid) chk64("m_l2addr", L2_S_R_ADDR, exp_l2addr);
    end
  end

  // ---------------- stimulus ----------------
  bit l2_auto = 1'b0;
  int l2_wait = 0;

  // Advance to the next falling edge. In auto mode, play the L2 role:
  // answer a held refill request after a random delay.
  task automatic tick();
    @(negedge clk);
    if (l2_auto) begin
      if (L2_S_R_DATA_VALID) begin
        L2_S_R_DATA_VALID = 1'b0;
      end else if (L2_S_R_ADDR_VALID) begin
        if (l2_wait == 0) begin
          L2_S_R_DATA = rand_line();
          L2_S_R_DATA_VALID = 1'b1;
        end else begin
          l2_wait--;
        end
      end else begin
        l2_wait = $urandom_range(0, 5);
        if ($urandom_range(0, 49) == 0) begin
          L2_S_R_DATA = rand_line();
          L2_S_R_DATA_VALID = 1'b1;
        end
      end
    end
  endtask

  task automatic refill(input logic [511:0] d, input int waits);
    repeat (waits) tick();
    L2_S_R_DATA = d;
    L2_S_R_DATA_VALID = 1'b1;
    tick();
    L2_S_R_DATA_VALID = 1'b0;
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a = (64'($urandom_range(0, 3)) * 64'(NS) + 64'($urandom_range(0, 7))) << 6;
    a[5:0] = 6'($urandom_range(0, 63));
    if ($urandom_range(0, 7) == 0) a[63:60] = 4'hF;
    return a;
  endfunction

  logic [511:0] line_l, line_m, line_n;

  initial begin
    reset = 1'b1;
    S_R_ADDR = '0; S_R_ADDR_VALID = 1'b0;
    L2_S_R_DATA = '0; L2_S_R_DATA_VALID = 1'b0;
    m_axi_acsnoop = 4'h0; m_axi_acaddr = '0;
    line_l = rand_line(); line_m = rand_line(); line_n = rand_line();

    tick();
    chk1("rst_dvalid", S_R_DATA_VALID, 1'b0);
    chk512("rst_data", S_R_DATA, '0);
    chk1("rst_l2valid", L2_S_R_ADDR_VALID, 1'b0);
    chk64("rst_l2addr", L2_S_R_ADDR, 64'h0);
    tick();
    reset = 1'b0;

    // First miss: refill request next cycle; L2 answers 5 cycles later.
    S_R_ADDR = 64'h1004; S_R_ADDR_VALID = 1'b1;
    tick();
    chk1("miss1_l2valid", L2_S_R_ADDR_VALID, 1'b1);
    chk64("miss1_l2addr", L2_S_R_ADDR, 64'h1000);
    chk1("miss1_nodv", S_R_DATA_VALID, 1'b0);
    repeat (4) begin
      tick();
      chk1("miss1_hold_v", L2_S_R_ADDR_VALID, 1'b1);
      chk64("miss1_hold_a", L2_S_R_ADDR, 64'h1000);
    end
    refill(line_l, 0);
    chk1("resp1_dvalid", S_R_DATA_VALID, 1'b1);
    chk512("resp1_data", S_R_DATA, line_l);
    chk1("resp1_l2off", L2_S_R_ADDR_VALID, 1'b0);
    S_R_ADDR_VALID = 1'b0;
    tick();
    chk1("resp1_once", S_R_DATA_VALID, 1'b0);
    chk512("resp1_hold", S_R_DATA, line_l);

    // Hit in the same line, held for two back-to-back responses.
    S_R_ADDR = 64'h1038; S_R_ADDR_VALID = 1'b1;
    tick();
    chk1("hit_dvalid", S_R_DATA_VALID, 1'b1);
    chk512("hit_data", S_R_DATA, line_l);
    chk1("hit_no_l2", L2_S_R_ADDR_VALID, 1'b0);
    tick();
    chk1("hit_b2b", S_R_DATA_VALID, 1'b1);
    S_R_ADDR_VALID = 1'b0;
    tick();

    // Conflict: 0x1000 + NS*64 uses the same set and evicts the line.
    S_R_ADDR = 64'h1000 + 64'(NS) * 64; S_R_ADDR_VALID = 1'b1;
    tick();
    chk1("conf_l2valid", L2_S_R_ADDR_VALID, 1'b1);
    chk64("conf_l2addr", L2_S_R_ADDR, 64'h1000 + 64'(NS) * 64);
    refill(line_m, 2);
    chk512("conf_data", S_R_DATA, line_m);
    S_R_ADDR_VALID = 1'b0;
    tick();
    S_R_ADDR = 64'h1000; S_R_ADDR_VALID = 1'b1;
    tick();
    chk1("evicted_miss", L2_S_R_ADDR_VALID, 1'b1);
    chk64("evicted_addr", L2_S_R_ADDR, 64'h1000);
    refill(line_l, 1);
    chk512("refetch_data", S_R_DATA, line_l);
    S_R_ADDR_VALID = 1'b0;
    tick();

    // Snoop-invalidate on line 0x1000.
    m_axi_acsnoop = 4'hD; m_axi_acaddr = 64'h1010;
    tick();
    m_axi_acsnoop = 4'h0;
    S_R_ADDR = 64'h1000; S_R_ADDR_VALID = 1'b1;
    tick();
`ifdef L1I_SNOOP_INV_EN
    chk1("snoop_miss", L2_S_R_ADDR_VALID, 1'b1);
    refill(line_l, 0);
    chk1("snoop_refill_dv", S_R_DATA_VALID, 1'b1);
    S_R_ADDR_VALID = 1'b0;
    tick();
    m_axi_acaddr = 64'h1000; S_R_ADDR = 64'h1000; S_R_ADDR_VALID = 1'b1;
    tick();
    chk1("nosnoop_hit", S_R_DATA_VALID, 1'b1);
    chk1("nosnoop_no_l2", L2_S_R_ADDR_VALID, 1'b0);
`else
    chk1("snoop_ignored_hit", S_R_DATA_VALID, 1'b1);
    chk1("snoop_ignored_no_l2", L2_S_R_ADDR_VALID, 1'b0);
`endif
    S_R_ADDR_VALID = 1'b0;
    tick();

    // The requester drops its request during the miss: the line installs but no strobe is sent.
    S_R_ADDR = 64'h2000; S_R_ADDR_VALID = 1'b1;
    tick();
    chk64("drop_l2addr", L2_S_R_ADDR, 64'h2000);
    S_R_ADDR_VALID = 1'b0;
    refill(line_n, 3);
    chk1("drop_nodv", S_R_DATA_VALID, 1'b0);
    chk512("drop_hold", S_R_DATA, line_l);
    tick();
    S_R_ADDR_VALID = 1'b1;
    tick();
    chk1("drop_then_hit", S_R_DATA_VALID, 1'b1);
    chk512("drop_hit_data", S_R_DATA, line_n);
    S_R_ADDR_VALID = 1'b0;
    tick();

    // Reset during a miss abandons the refill; a late L2 strobe is ignored.
    S_R_ADDR = 64'h3000; S_R_ADDR_VALID = 1'b1;
    tick();
    chk1("rmiss_l2valid", L2_S_R_ADDR_VALID, 1'b1);
    reset = 1'b1; S_R_ADDR_VALID = 1'b0;
    tick();
    chk1("rmiss_l2off", L2_S_R_ADDR_VALID, 1'b0);
    reset = 1'b0;
    L2_S_R_DATA = line_m; L2_S_R_DATA_VALID = 1'b1;
    tick();
    L2_S_R_DATA_VALID = 1'b0;
    chk1("late_fill_nodv", S_R_DATA_VALID, 1'b0);
    S_R_ADDR_VALID = 1'b1;
    tick();
    chk1("late_fill_miss", L2_S_R_ADDR_VALID, 1'b1);
    chk64("late_fill_addr", L2_S_R_ADDR, 64'h3000);
    refill(line_n, 0);
    S_R_ADDR_VALID = 1'b0;
    tick();

    // Randomized traffic: the compare process checks every cycle against the model.
    l2_auto = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) != 0) S_R_ADDR = rand_addr();
      S_R_ADDR_VALID = ($urandom_range(0, 9) < 7);
      m_axi_acsnoop = ($urandom_range(0, 3) == 0) ? 4'hD : 4'($urandom_range(0, 12));
      m_axi_acaddr = rand_addr();
    end
    reset = 1'b0; S_R_ADDR_VALID = 1'b0; m_axi_acsnoop = 4'h0;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
